// File: rtl/mc_chroma_ip_ctrl_pkg.sv
// Shared encodings for the chroma interpolator sequencer: block-size codes,
// plane codes, rows-per-column constants and the controller state type.
package mc_chroma_ip_ctrl_pkg;

  // Chroma block dimension code: 0=4, 1=8, 2=16, 3=32 samples.
  typedef enum logic [1:0] {
    BLK_4  = 2'd0,
    BLK_8  = 2'd1,
    BLK_16 = 2'd2,
    BLK_32 = 2'd3
  } blk_code_e;

  localparam logic PLANE_U = 1'b0;
  localparam logic PLANE_V = 1'b1;

  // Input rows fetched per output column: a fractional vertical phase needs
  // the 4-tap filter support (3 extra rows), an integer one does not.
  localparam logic [2:0] ROWS_FRAC = 3'd7;
  localparam logic [2:0] ROWS_INT  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_e;

  // Index of the last column (W-1) for a width code.
  function automatic logic [4:0] col_last(input logic [1:0] code);
    col_last = 5'd3;
    case (code)
      BLK_4:   col_last = 5'd3;
      BLK_8:   col_last = 5'd7;
      BLK_16:  col_last = 5'd15;
      BLK_32:  col_last = 5'd31;
      default: col_last = 5'd3;
    endcase
  endfunction

  // Index of the last 4-row strip (H/4-1) for a height code.
  function automatic logic [2:0] strip_last(input logic [1:0] code);
    strip_last = 3'd0;
    case (code)
      BLK_4:   strip_last = 3'd0;
      BLK_8:   strip_last = 3'd1;
      BLK_16:  strip_last = 3'd3;
      BLK_32:  strip_last = 3'd7;
      default: strip_last = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mc_chroma_ip_addr_gen.sv
// Reference read address walker for one chroma PU.
// Nesting, innermost first: row r, column c, strip s, plane p.
// last is high on the final read of the PU; stepping on last wraps to zero.
module mc_chroma_ip_addr_gen
  import mc_chroma_ip_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       step,
  input  logic       frac_rows,
  input  logic [1:0] w_code,
  input  logic [1:0] h_code,
  output logic       plane,
  output logic [4:0] col,
  output logic [5:0] row_y,
  output logic       last
);

  logic [2:0] r_q;
  logic [4:0] c_q;
  logic [2:0] s_q;
  logic       p_q;
  logic [2:0] r_last;
  logic       r_end;
  logic       c_end;
  logic       s_end;

  // End-of-loop detection for each nesting level
  always_comb begin
    r_last = frac_rows ? (ROWS_FRAC - 3'd1) : (ROWS_INT - 3'd1);
    r_end  = (r_q == r_last);
    c_end  = (c_q == col_last(w_code));
    s_end  = (s_q == strip_last(h_code));
    last   = r_end & c_end & s_end & (p_q == PLANE_V);
  end

  // Nested counters: each level advances when all inner levels wrap
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= '0;
      c_q <= '0;
      s_q <= '0;
      p_q <= PLANE_U;
    end else if (clear) begin
      r_q <= '0;
      c_q <= '0;
      s_q <= '0;
      p_q <= PLANE_U;
    end else if (step) begin
      if (!r_end) begin
        r_q <= r_q + 3'd1;
      end else begin
        r_q <= '0;
        if (!c_end) begin
          c_q <= c_q + 5'd1;
        end else begin
          c_q <= '0;
          if (!s_end) begin
            s_q <= s_q + 3'd1;
          end else begin
            s_q <= '0;
            p_q <= ~p_q;
          end
        end
      end
    end
  end

  // Row relative to buffer origin (intY-1): integer phase skips the top
  // filter-support row.
  always_comb begin
    plane = p_q;
    col   = c_q;
    row_y = {1'b0, s_q, 2'b00} + {3'b000, r_q} + (frac_rows ? 6'd0 : 6'd1);
  end

endmodule

// File: rtl/mc_chroma_ip_ctrl.sv
// Sequencer for the single-pipe chroma fractional interpolator.
// Walks a chroma PU (U then V, 4-row strips, columns, input rows), issues one
// reference read per cycle, drives blk_start/frac/ref_valid, and maps returned
// fractional pixels to prediction-buffer write coordinates.
// Handshake: there is no back-pressure; a read issued with ref_rd_en_o is
// presented to the interpolator as ref_valid_o exactly RD_LAT cycles later,
// and every ip_valid_i seen in FETCH/DRAIN is one output pixel, written in
// the same cycle via wr_en_o.
// Optional feature macro MC_CHROMA_CTRL_TMO_EN: drain timeout with sticky
// err_o; without it DRAIN waits indefinitely and err_o stays low.
module mc_chroma_ip_ctrl
  import mc_chroma_ip_ctrl_pkg::*;
#(
  parameter int RD_LAT    = 1,
  parameter int DRAIN_TMO = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_i,
  input  logic [1:0] blk_w_i,
  input  logic [1:0] blk_h_i,
  input  logic [2:0] fracx_i,
  input  logic [2:0] fracy_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       ref_rd_en_o,
  output logic       ref_rd_plane_o,
  output logic [5:0] ref_rd_x_o,
  output logic [5:0] ref_rd_y_o,
  output logic       ip_blk_start_o,
  output logic [2:0] ip_fracx_o,
  output logic [2:0] ip_fracy_o,
  output logic       ref_valid_o,
  input  logic       ip_valid_i,
  output logic       wr_en_o,
  output logic       wr_plane_o,
  output logic [4:0] wr_x_o,
  output logic [4:0] wr_y_o
);

  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [1:0]        w_q;
  logic [1:0]        h_q;
  logic [2:0]        fracx_q;
  logic [2:0]        fracy_q;
  logic              start_acc;
  logic              count_en;
  logic              drain_full;
  logic              tmo_hit;
  logic              ag_plane;
  logic [4:0]        ag_col;
  logic [5:0]        ag_row;
  logic              ag_last;
  logic [RD_LAT-1:0] rv_q;
  logic [11:0]       out_cnt_q;
  logic [11:0]       out_total;
  logic [1:0]        ok_q;
  logic [4:0]        oc_q;
  logic [2:0]        os_q;
  logic              op_q;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; start is only accepted from IDLE
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_INIT;
        end
      end
      ST_INIT:  state_d = ST_FETCH;
      ST_FETCH: if (ag_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_full || tmo_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // PU configuration, held from accepted start until the next one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q     <= '0;
      h_q     <= '0;
      fracx_q <= '0;
      fracy_q <= '0;
    end else if (start_acc) begin
      w_q     <= blk_w_i;
      h_q     <= blk_h_i;
      fracx_q <= fracx_i;
      fracy_q <= fracy_i;
    end
  end

  mc_chroma_ip_addr_gen u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (start_acc),
    .step      (ref_rd_en_o),
    .frac_rows (fracy_q != 3'd0),
    .w_code    (w_q),
    .h_code    (h_q),
    .plane     (ag_plane),
    .col       (ag_col),
    .row_y     (ag_row),
    .last      (ag_last)
  );

  // Status, interpolator control and read-port outputs; address is forced to
  // zero outside reads so the port is quiet when idle
  always_comb begin
    busy_o         = (state_q != ST_IDLE);
    done_o         = (state_q == ST_DONE);
    ip_blk_start_o = (state_q == ST_INIT);
    ref_rd_en_o    = (state_q == ST_FETCH);
    ref_rd_plane_o = ref_rd_en_o ? ag_plane : 1'b0;
    ref_rd_x_o     = ref_rd_en_o ? {1'b0, ag_col} : 6'd0;
    ref_rd_y_o     = ref_rd_en_o ? ag_row : 6'd0;
    ip_fracx_o     = fracx_q;
    ip_fracy_o     = fracy_q;
    ref_valid_o    = rv_q[RD_LAT-1];
  end

  // Read-data valid delay line matching the reference buffer latency
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rv_q <= '0;
    end else begin
      rv_q[0] <= ref_rd_en_o;
      for (int i = 1; i < RD_LAT; i++) rv_q[i] <= rv_q[i-1];
    end
  end

  // Output accounting: 2*W*H = 32 << (w_code + h_code)
  always_comb begin
    count_en   = ip_valid_i & ((state_q == ST_FETCH) | (state_q == ST_DRAIN));
    out_total  = 12'd32 << ({1'b0, w_q} + {1'b0, h_q});
    drain_full = ((out_cnt_q + {11'd0, count_en}) == out_total);
    wr_en_o    = count_en;
    wr_plane_o = op_q;
    wr_x_o     = oc_q;
    wr_y_o     = {os_q, ok_q};
  end

  // Output coordinate counter: row-in-strip k, column, strip, plane
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_cnt_q <= '0;
      ok_q      <= '0;
      oc_q      <= '0;
      os_q      <= '0;
      op_q      <= PLANE_U;
    end else if (start_acc) begin
      out_cnt_q <= '0;
      ok_q      <= '0;
      oc_q      <= '0;
      os_q      <= '0;
      op_q      <= PLANE_U;
    end else if (count_en) begin
      out_cnt_q <= out_cnt_q + 12'd1;
      ok_q      <= ok_q + 2'd1;
      if (ok_q == 2'd3) begin
        if (oc_q == col_last(w_q)) begin
          oc_q <= '0;
          if (os_q == strip_last(h_q)) begin
            os_q <= '0;
            op_q <= ~op_q;
          end else begin
            os_q <= os_q + 3'd1;
          end
        end else begin
          oc_q <= oc_q + 5'd1;
        end
      end
    end
  end

`ifdef MC_CHROMA_CTRL_TMO_EN
  localparam int TMO_W = $clog2(DRAIN_TMO + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // Timeout fires on the DRAIN_TMO-th consecutive DRAIN cycle without a pixel
  always_comb begin
    tmo_hit = (state_q == ST_DRAIN) && !ip_valid_i && !drain_full &&
              (tmo_q == TMO_W'(DRAIN_TMO - 1));
    err_o   = err_q;
  end

  // Idle-cycle counter in DRAIN and sticky error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state_q != ST_DRAIN) || ip_valid_i) tmo_q <= '0;
      else                                     tmo_q <= tmo_q + 1'b1;
      if (start_acc)    err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end
`else
  // No timeout: DRAIN waits for every pixel. err_o stays low for any legal
  // DRAIN_TMO (>= 1); a nonsensical setting shows up as a stuck error.
  always_comb begin
    tmo_hit = 1'b0;
    err_o   = (DRAIN_TMO < 1);
  end
`endif

endmodule

// File: tb/tb_mc_chroma_ip_ctrl.sv
// Directed bench for mc_chroma_ip_ctrl: expected read addresses and write
// coordinates are queued when a PU is started; a negedge monitor pops and
// compares whenever the DUT strobes a read or a write.
module tb_mc_chroma_ip_ctrl;

  localparam int RD_LAT    = 1;
  localparam int DRAIN_TMO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start_i = 1'b0;
  logic [1:0] blk_w_i = '0;
  logic [1:0] blk_h_i = '0;
  logic [2:0] fracx_i = '0;
  logic [2:0] fracy_i = '0;
  logic       ip_valid_i = 1'b0;
  logic       busy_o, done_o, err_o;
  logic       ref_rd_en_o, ref_rd_plane_o;
  logic [5:0] ref_rd_x_o, ref_rd_y_o;
  logic       ip_blk_start_o;
  logic [2:0] ip_fracx_o, ip_fracy_o;
  logic       ref_valid_o;
  logic       wr_en_o, wr_plane_o;
  logic [4:0] wr_x_o, wr_y_o;

  always #5 clk = ~clk;

  mc_chroma_ip_ctrl #(.RD_LAT(RD_LAT), .DRAIN_TMO(DRAIN_TMO)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .blk_w_i        (blk_w_i),
    .blk_h_i        (blk_h_i),
    .fracx_i        (fracx_i),
    .fracy_i        (fracy_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .ref_rd_en_o    (ref_rd_en_o),
    .ref_rd_plane_o (ref_rd_plane_o),
    .ref_rd_x_o     (ref_rd_x_o),
    .ref_rd_y_o     (ref_rd_y_o),
    .ip_blk_start_o (ip_blk_start_o),
    .ip_fracx_o     (ip_fracx_o),
    .ip_fracy_o     (ip_fracy_o),
    .ref_valid_o    (ref_valid_o),
    .ip_valid_i     (ip_valid_i),
    .wr_en_o        (wr_en_o),
    .wr_plane_o     (wr_plane_o),
    .wr_x_o         (wr_x_o),
    .wr_y_o         (wr_y_o)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [12:0] exp_rd_q[$];   // {plane, x[5:0], y[5:0]}
  logic [10:0] exp_wr_q[$];   // {plane, x[4:0], y[4:0]}
  logic [12:0] e_rd;
  logic [10:0] e_wr;
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_bs = 0;
  logic [3:0]  rd_hist = '0;
  logic        prev_bs = 1'b0;
  logic        first_rd_pending = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      rd_hist = '0;
      prev_bs = 1'b0;
    end else begin
      if (ref_rd_en_o) begin
        n_rd++;
        if (first_rd_pending) begin
          check("blk_start_before_first_read", 64'(prev_bs), 64'd1);
          first_rd_pending = 1'b0;
        end
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected: got read p%0d x%0d y%0d, none expected",
                   ref_rd_plane_o, ref_rd_x_o, ref_rd_y_o);
        end else begin
          e_rd = exp_rd_q.pop_front();
          check("rd_addr", 64'({ref_rd_plane_o, ref_rd_x_o, ref_rd_y_o}), 64'(e_rd));
        end
      end
      if (wr_en_o) begin
        n_wr++;
        if (exp_wr_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wr_unexpected: got write p%0d x%0d y%0d, none expected",
                   wr_plane_o, wr_x_o, wr_y_o);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_coord", 64'({wr_plane_o, wr_x_o, wr_y_o}), 64'(e_wr));
        end
      end
      if (ref_valid_o || rd_hist[RD_LAT-1])
        check("ref_valid_lag", 64'(ref_valid_o), 64'(rd_hist[RD_LAT-1]));
      rd_hist = {rd_hist[2:0], ref_rd_en_o};
      if (ip_blk_start_o) n_bs++;
      prev_bs = ip_blk_start_o;
    end
  end

  // ---------------- drivers ----------------
  task automatic push_pu(input int wc, input int hc, input int fy);
    int w, h, rows, off;
    w    = 4 << wc;
    h    = 4 << hc;
    rows = (fy != 0) ? 7 : 4;
    off  = (fy != 0) ? 0 : 1;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < h / 4; s++)
        for (int c = 0; c < w; c++)
          for (int r = 0; r < rows; r++)
            exp_rd_q.push_back({1'(p), 6'(c), 6'(4 * s + r + off)});
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < h / 4; s++)
        for (int c = 0; c < w; c++)
          for (int k = 0; k < 4; k++)
            exp_wr_q.push_back({1'(p), 5'(c), 5'(4 * s + k)});
  endtask

  task automatic pulse_start(input int wc, input int hc, input int fx, input int fy);
    @(posedge clk); #1;
    blk_w_i = 2'(wc);
    blk_h_i = 2'(hc);
    fracx_i = 3'(fx);
    fracy_i = 3'(fy);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Runs one PU. exp_reads / exp_writes are hand-computed totals.
  // withhold > 0 leaves that many pixels unreturned (timeout build only).
  task automatic run_pu(input int wc, input int hc, input int fx, input int fy,
                        input bit mid_start, input int withhold,
                        input int exp_reads, input int exp_writes);
    int idle;
    n_rd = 0;
    n_wr = 0;
    n_bs = 0;
    push_pu(wc, hc, fy);
    first_rd_pending = 1'b1;
    pulse_start(wc, hc, fx, fy);
    @(negedge clk);
    check("init_blk_start", 64'(ip_blk_start_o), 64'd1);
    check("busy_after_start", 64'(busy_o), 64'd1);
    check("err_clear_on_start", 64'(err_o), 64'd0);
    check("ip_frac", 64'({ip_fracx_o, ip_fracy_o}), 64'({3'(fx), 3'(fy)}));
    if (mid_start) begin
      repeat (10) @(posedge clk);
      #1;
      blk_w_i = 2'd3;
      blk_h_i = 2'd3;
      fracx_i = 3'(fx + 1);
      fracy_i = 3'd0;
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    for (int i = 0; i < 5000 && exp_rd_q.size() != 0; i++) @(posedge clk);
    #1;
    if (exp_rd_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL rd_timeout: %0d reads still pending", exp_rd_q.size());
      exp_rd_q.delete();
    end
    check("read_count", 64'(n_rd), 64'(exp_reads));
    check("ip_frac_held", 64'({ip_fracx_o, ip_fracy_o}), 64'({3'(fx), 3'(fy)}));
    for (int i = 0; i < exp_writes - withhold; i++) begin
      ip_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    ip_valid_i = 1'b0;
    if (withhold == 0) begin
      @(negedge clk);
      check("done_after_last_write", 64'(done_o), 64'd1);
      check("write_count", 64'(n_wr), 64'(exp_writes));
      check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
      check("err_clean", 64'(err_o), 64'd0);
    end else begin
      idle = 0;
      for (int i = 1; i <= 100; i++) begin
        @(negedge clk);
        if (done_o) begin
          idle = i;
          break;
        end
      end
      check("tmo_done_delay", 64'(idle), 64'd17);
      check("tmo_err_set", 64'(err_o), 64'd1);
      check("tmo_write_count", 64'(n_wr), 64'(exp_writes - withhold));
      exp_wr_q.delete();
    end
    @(negedge clk);
    check("done_one_cycle", 64'(done_o), 64'd0);
    check("idle_after_done", 64'(busy_o), 64'd0);
    check("single_blk_start", 64'(n_bs), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    #2;
    check("reset_outputs", 64'({busy_o, done_o, err_o, ref_rd_en_o, ref_rd_plane_o,
          ref_rd_x_o, ref_rd_y_o, ip_blk_start_o, ip_fracx_o, ip_fracy_o,
          ref_valid_o, wr_en_o, wr_plane_o, wr_x_o, wr_y_o}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // pixel strobe while idle must not write or count
    @(posedge clk); #1 ip_valid_i = 1'b1;
    @(negedge clk);
    check("idle_valid_ignored", 64'(wr_en_o), 64'd0);
    @(posedge clk); #1 ip_valid_i = 1'b0;

    // 4x4 integer vertical phase: 2*4*4*1 = 32 reads, 32 writes
    run_pu(0, 0, 2, 0, 1'b0, 0, 32, 32);
    // 4x4 fractional: 2*4*7 = 56 reads; stray start mid-fetch ignored
    run_pu(0, 0, 1, 3, 1'b1, 0, 56, 32);
    // 8x8 fractional: 2*8*7*2 = 224 reads, 128 writes
    run_pu(1, 1, 4, 5, 1'b0, 0, 224, 128);
    // 4x8 integer: 2*4*4*2 = 64 reads, 64 writes
    run_pu(0, 1, 7, 0, 1'b0, 0, 64, 64);

    // reset in the middle of FETCH
    n_rd = 0;
    push_pu(1, 1, 5);
    pulse_start(1, 1, 3, 5);
    repeat (20) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("midop_reset_outputs", 64'({busy_o, done_o, err_o, ref_rd_en_o, ref_rd_plane_o,
          ref_rd_x_o, ref_rd_y_o, ip_blk_start_o, ip_fracx_o, ip_fracy_o,
          ref_valid_o, wr_en_o, wr_plane_o, wr_x_o, wr_y_o}), 64'd0);
    exp_rd_q.delete();
    exp_wr_q.delete();
    first_rd_pending = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run_pu(0, 0, 2, 0, 1'b0, 0, 32, 32);

`ifdef MC_CHROMA_CTRL_TMO_EN
    run_pu(0, 0, 2, 0, 1'b0, 3, 32, 32);
    run_pu(0, 0, 0, 0, 1'b0, 0, 32, 32);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // overall bound in case the design never completes
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
